// File: rtl/picorv32_mem_responder.sv
// Wait-state memory model for the PicoRV32 native memory interface.
// Single-port word RAM with byte strobes, fixed response latency and sticky error flags.
module picorv32_mem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err_oob,
    output logic        err_proto,
    output logic [15:0] req_count
);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN      = 32'(MEM_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, nxt;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_unused;

    logic [31:0] ram [MEM_WORDS];

    logic [31:0] cur_addr, cur_wdata, diff;
    logic [3:0]  cur_wstrb;
    logic        in_range, enter_resp;

    // With zero wait cycles the response is formed on the accept edge, so
    // the live request must be used before it has been latched.
    always_comb begin
        cur_addr  = (state == IDLE) ? mem_addr  : addr_q;
        cur_wdata = (state == IDLE) ? mem_wdata : wdata_q;
        cur_wstrb = (state == IDLE) ? mem_wstrb : wstrb_q;
        diff      = cur_addr - BASE_ADDR;
        in_range  = diff < SPAN;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (mem_valid) nxt = (WAIT_INIT == 4'd0) ? RESP : WAIT;
            WAIT:    if (cnt <= 4'd1) nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign enter_resp = (nxt == RESP);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt          <= 4'd0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            instr_unused <= 1'b0;
            mem_ready    <= 1'b0;
            mem_rdata    <= 32'h0;
            err_oob      <= 1'b0;
            err_proto    <= 1'b0;
            req_count    <= 16'h0;
        end else begin
            if (state == IDLE && mem_valid) begin
                addr_q       <= mem_addr;
                wdata_q      <= mem_wdata;
                wstrb_q      <= mem_wstrb;
                instr_unused <= mem_instr;
                cnt          <= WAIT_INIT;
            end
            if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                if (!mem_valid || mem_addr != addr_q || mem_wstrb != wstrb_q)
                    err_proto <= 1'b1;
            end
            mem_ready <= enter_resp;
            if (enter_resp) begin
                if (in_range && cur_wstrb == 4'h0) mem_rdata <= ram[diff[IDX_W+1:2]];
                else                               mem_rdata <= 32'h0;
                if (!in_range) err_oob <= 1'b1;
            end
            if (mem_ready) req_count <= req_count + 16'd1;
        end
    end

    // RAM is never cleared; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (resetn && enter_resp && in_range) begin
            for (int i = 0; i < 4; i++)
                if (cur_wstrb[i]) ram[diff[IDX_W+1:2]][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Bench for picorv32_mem_responder: directed scenarios plus random traffic
// against a word-array reference model; a second instance covers zero wait cycles.
module tb_picorv32_mem_responder;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid = 0, a_instr = 0;
    logic [31:0] a_addr = 0, a_wdata = 0;
    logic [3:0]  a_wstrb = 0;
    logic        a_ready, a_oob, a_proto;
    logic [31:0] a_rdata;
    logic [15:0] a_cnt;

    logic        b_valid = 0, b_instr = 0;
    logic [31:0] b_addr = 0, b_wdata = 0;
    logic [3:0]  b_wstrb = 0;
    logic        b_ready, b_oob, b_proto;
    logic [31:0] b_rdata;
    logic [15:0] b_cnt;

    picorv32_mem_responder #(.MEM_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .resetn(resetn), .mem_valid(a_valid), .mem_instr(a_instr),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wstrb(a_wstrb),
        .mem_ready(a_ready), .mem_rdata(a_rdata), .err_oob(a_oob),
        .err_proto(a_proto), .req_count(a_cnt));

    picorv32_mem_responder #(.MEM_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .resetn(resetn), .mem_valid(b_valid), .mem_instr(b_instr),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb),
        .mem_ready(b_ready), .mem_rdata(b_rdata), .err_oob(b_oob),
        .err_proto(b_proto), .req_count(b_cnt));

    int n_chk = 0;
    int n_fail = 0;

    bit [31:0]   m_ram [1024];
    bit          m_wr  [1024];
    bit          m_oob, m_proto;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on dut_a, started in the current (negedge) cycle.
    task automatic req(input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, input bit drop);
        int k, idx;
        bit in_r, chk_rd;
        logic [31:0] exp_rd;
        in_r   = addr < 32'd4096;
        idx    = int'(addr >> 2) % 1024;
        chk_rd = 1;
        exp_rd = 32'h0;
        if (!in_r) m_oob = 1;
        else if (ws != 4'h0) begin
            for (int b = 0; b < 4; b++) if (ws[b]) m_ram[idx][8*b +: 8] = wd[8*b +: 8];
            if (ws == 4'hF) m_wr[idx] = 1;
        end else begin
            exp_rd = m_ram[idx];
            chk_rd = m_wr[idx];
        end
        if (drop) m_proto = 1;
        m_cnt = m_cnt + 16'd1;

        a_valid = 1; a_addr = addr; a_wdata = wd; a_wstrb = ws;
        a_instr = (ws == 4'h0) ? 1'($urandom_range(0, 1)) : 1'b0;
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (drop && c == 1) a_valid = 0;
            if (a_ready) begin k = c; break; end
        end
        chk("latency", k, 3);
        if (chk_rd) chk("rdata", a_rdata, exp_rd);
        a_valid = 0;
        @(negedge clk);
        chk("ready_width", {31'h0, a_ready}, 0);
        chk("req_count", {16'h0, a_cnt}, {16'h0, m_cnt});
        chk("err_oob", {31'h0, a_oob}, {31'h0, m_oob});
        chk("err_proto", {31'h0, a_proto}, {31'h0, m_proto});
    endtask

    task automatic do_reset(input int cycles);
        resetn = 0;
        repeat (cycles) @(negedge clk);
        m_oob = 0; m_proto = 0; m_cnt = 0;
        chk("rst_ready", {31'h0, a_ready}, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_flags", {30'h0, a_oob, a_proto}, 0);
        chk("rst_count", {16'h0, a_cnt}, 0);
        a_valid = 0;
        resetn = 1;
    endtask

    initial begin
        logic [31:0] addr, wd;
        logic [3:0]  ws;
        m_oob = 0; m_proto = 0; m_cnt = 0;

        // Reset with mem_valid asserted: the request must be ignored.
        @(negedge clk);
        a_valid = 1; a_addr = 32'h10; a_wstrb = 4'h0;
        do_reset(3);
        chk("b_rst_ready", {31'h0, b_ready}, 0);
        chk("b_rst_count", {16'h0, b_cnt}, 0);
        @(negedge clk);

        req(32'h10, 32'hDEADBEEF, 4'hF, 0);
        req(32'h10, 32'h0, 4'h0, 0);
        chk("count_two", {16'h0, a_cnt}, 2);

        req(32'h10, 32'h0000_5500, 4'b0010, 0);
        req(32'h10, 32'h0, 4'h0, 0);

        req(32'h0, 32'h1234_5678, 4'hF, 0);
        req(32'h1000, 32'hCAFE_F00D, 4'hF, 0);
        req(32'h1000, 32'h0, 4'h0, 0);
        req(32'h0, 32'h0, 4'h0, 0);
        req(32'h10, 32'h0, 4'h0, 0);

        req(32'h10, 32'h0, 4'h0, 1);
        do_reset(2);
        @(negedge clk);

        // Reset in the middle of a write: no pulse, RAM keeps the old word.
        req(32'h20, 32'hA5A5_A5A5, 4'hF, 0);
        a_valid = 1; a_addr = 32'h20; a_wdata = 32'h0BAD_F00D; a_wstrb = 4'hF;
        @(negedge clk);
        chk("abort_ready0", {31'h0, a_ready}, 0);
        resetn = 0;
        @(negedge clk);
        chk("abort_ready1", {31'h0, a_ready}, 0);
        @(negedge clk);
        chk("abort_ready2", {31'h0, a_ready}, 0);
        a_valid = 0; resetn = 1;
        m_oob = 0; m_proto = 0; m_cnt = 0;
        @(negedge clk);
        chk("abort_ready3", {31'h0, a_ready}, 0);
        chk("abort_count", {16'h0, a_cnt}, 0);
        req(32'h20, 32'h0, 4'h0, 0);

        // Random traffic over a 16-word window plus out-of-range addresses.
        for (int i = 0; i < 16; i++) req(32'(i * 4), $urandom, 4'hF, 0);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       addr = 32'h1000 + 32'($urandom_range(0, 255) * 4);
                1:       addr = 32'hFFFF_FFFC;
                default: addr = 32'($urandom_range(0, 15) * 4);
            endcase
            addr = addr | 32'($urandom_range(0, 3));
            wd   = $urandom;
            ws   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            req(addr, wd, ws, 0);
        end

        // Zero wait cycles, back-to-back requests on dut_b.
        b_valid = 1; b_addr = 32'h4; b_wdata = 32'h7777_0077; b_wstrb = 4'hF;
        @(negedge clk);
        chk("b2b_ready_t1", {31'h0, b_ready}, 1);
        b_addr = 32'h4; b_wstrb = 4'h0; b_instr = 1;
        @(negedge clk);
        chk("b2b_ready_t2", {31'h0, b_ready}, 0);
        @(negedge clk);
        chk("b2b_ready_t3", {31'h0, b_ready}, 1);
        chk("b2b_rdata", b_rdata, 32'h7777_0077);
        b_valid = 0;
        @(negedge clk);
        chk("b2b_ready_t4", {31'h0, b_ready}, 0);
        chk("b2b_count", {16'h0, b_cnt}, 2);
        chk("b2b_flags", {30'h0, b_oob, b_proto}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
